// File: rtl/timer_arbiter_if.sv
// Bundle of requester-side and timer-side signals around the timer arbiter.
interface timer_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int LEN_W = 10
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*LEN_W-1:0] req_length;
  logic [N_REQ-1:0]       grant;
  logic [N_REQ-1:0]       done;
  logic                   busy;
  logic                   timer_start;
  logic [LEN_W-1:0]       timer_length;
  logic                   timer_expired;

  // Arbiter side
  modport slave (
    input  req, req_length, timer_expired,
    output grant, done, busy, timer_start, timer_length
  );

  // Requesters plus timer side
  modport master (
    output req, req_length, timer_expired,
    input  grant, done, busy, timer_start, timer_length
  );
endinterface

// File: rtl/timer_arbiter.sv
// Round-robin sharing of a single programmable timer among N_REQ requesters.
// A granted requester's length is loaded into the timer; on expiry the owner
// gets a one-cycle done. Dropping req while waiting abandons the interval.
module timer_arbiter #(
  parameter int N_REQ = 4,
  parameter int LEN_W = 10
) (
  input  logic            clk,
  input  logic            reset_n,
  timer_arbiter_if.slave  bus
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic               busy_q, busy_d;
  logic               start_q, start_d;
  logic [LEN_W-1:0]   length_q, length_d;
  logic [PTR_W-1:0]   rr_q, rr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;

  logic               win_valid;
  logic [PTR_W-1:0]   win_idx;
  int unsigned        scan_idx;
  logic [LEN_W-1:0]   len_arr [N_REQ];

  // Split the flat length bus into one field per requester
  for (genvar g = 0; g < N_REQ; g++) begin : g_len
    assign len_arr[g] = bus.req_length[g*LEN_W +: LEN_W];
  end

  // Round-robin search: first set req at or above the pointer, wrapping
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    scan_idx  = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      scan_idx = i + 32'(rr_q);
      if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
      if (!win_valid && bus.req[PTR_W'(scan_idx)]) begin
        win_valid = 1'b1;
        win_idx   = PTR_W'(scan_idx);
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
      length_q <= '0;
      rr_q     <= '0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      start_q  <= start_d;
      length_q <= length_d;
      rr_q     <= rr_d;
      owner_q  <= owner_d;
    end
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_valid) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (bus.timer_expired || !bus.req[owner_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; expiry has priority over abort
  always_comb begin
    grant_d  = grant_q;
    done_d   = '0;
    busy_d   = busy_q;
    start_d  = 1'b0;
    length_d = length_q;
    rr_d     = rr_q;
    owner_d  = owner_q;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        if (win_valid) begin
          grant_d  = N_REQ'(1) << win_idx;
          length_d = len_arr[win_idx];
          start_d  = 1'b1;
          busy_d   = 1'b1;
          owner_d  = win_idx;
          rr_d     = (32'(win_idx) == N_REQ - 1) ? '0 : win_idx + 1'b1;
        end
      end
      START: begin
        // expiry seen here is stale from an earlier interval
      end
      WAIT: begin
        if (bus.timer_expired) begin
          done_d  = grant_q;
          grant_d = '0;
          busy_d  = 1'b0;
        end else if (!bus.req[owner_q]) begin
          grant_d = '0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.grant        = grant_q;
  assign bus.done         = done_q;
  assign bus.busy         = busy_q;
  assign bus.timer_start  = start_q;
  assign bus.timer_length = length_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Self-checking bench for timer_arbiter with a 1-tick-per-cycle timer model.
module tb_timer_arbiter;
  localparam int N_REQ = 4;
  localparam int LEN_W = 10;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  timer_arbiter_if #(.N_REQ(N_REQ), .LEN_W(LEN_W)) bus ();

  timer_arbiter #(.N_REQ(N_REQ), .LEN_W(LEN_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [N_REQ-1:0] grant;
    logic [LEN_W-1:0] len;
  } start_t;

  start_t           start_q [$];
  logic [N_REQ-1:0] done_q  [$];

  // Timer model: loads on start, expires len+1 edges after the load edge
  logic        manual_exp = 1'b0;
  logic        model_exp;
  logic        armed;
  int unsigned cnt;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      model_exp <= 1'b0;
      armed     <= 1'b0;
      cnt       <= 0;
    end else begin
      model_exp <= 1'b0;
      if (bus.timer_start) begin
        cnt   <= bus.timer_length;
        armed <= 1'b1;
      end else if (armed) begin
        if (cnt == 0) begin
          model_exp <= 1'b1;
          armed     <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end
  assign bus.timer_expired = model_exp | manual_exp;

  task automatic set_len(input int i, input logic [LEN_W-1:0] v);
    bus.req_length[i*LEN_W +: LEN_W] = v;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.req = '0;
    bus.req_length = '0;
    manual_exp = 1'b0;
    start_q.delete();
    done_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Waits on negedges until the timer expiry is visible; bounded
  task automatic wait_expiry(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (bus.timer_expired === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    start_t e;
    reset_n = 1'b0;
    bus.req = '0;
    bus.req_length = '0;
    repeat (2) @(negedge clk);
    total++;
    if (bus.grant !== '0) begin bad++; $display("FAIL reset_grant: got %b want 0000", bus.grant); end
    total++;
    if (bus.done !== '0) begin bad++; $display("FAIL reset_done: got %b want 0000", bus.done); end
    total++;
    if ({bus.busy, bus.timer_start} !== 2'b00) begin
      bad++; $display("FAIL reset_busy_start: got %b want 00", {bus.busy, bus.timer_start});
    end
    total++;
    if (bus.timer_length !== '0) begin bad++; $display("FAIL reset_length: got %0d want 0", bus.timer_length); end
    reset_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_single();
    start_t e;
    logic [N_REQ-1:0] ed;
    bit seen;
    do_reset();
    set_len(1, 10'd3);
    bus.req = 4'b0010;
    start_q.push_back('{grant: 4'b0010, len: 10'd3});
    @(negedge clk);
    e = start_q.pop_front();
    total++;
    if (bus.timer_start !== 1'b1 || bus.grant !== e.grant || bus.timer_length !== e.len || bus.busy !== 1'b1) begin
      bad++; $display("FAIL single_start: start=%b grant=%b len=%0d busy=%b want 1 %b %0d 1",
                      bus.timer_start, bus.grant, bus.timer_length, bus.busy, e.grant, e.len);
    end
    @(negedge clk);
    total++;
    if (bus.timer_start !== 1'b0 || bus.busy !== 1'b1) begin
      bad++; $display("FAIL single_wait: start=%b busy=%b want 0 1", bus.timer_start, bus.busy);
    end
    wait_expiry(seen);
    total++;
    if (!seen) begin bad++; $display("FAIL single_expiry_timeout: got none want expiry"); end
    done_q.push_back(4'b0010);
    @(negedge clk);
    ed = done_q.pop_front();
    total++;
    if (bus.done !== ed || bus.grant !== '0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL single_done: done=%b grant=%b busy=%b want %b 0000 0", bus.done, bus.grant, bus.busy, ed);
    end
    bus.req = '0;
    @(negedge clk);
    total++;
    if (bus.done !== '0) begin bad++; $display("FAIL single_done_width: got %b want 0000", bus.done); end
  endtask

  task automatic test_back_to_back();
    int order [5] = '{0, 1, 2, 3, 0};
    start_t e;
    logic [N_REQ-1:0] ed;
    bit seen;
    do_reset();
    for (int i = 0; i < N_REQ; i++) set_len(i, LEN_W'(i + 2));
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) start_q.push_back('{grant: 4'(1 << order[k]), len: LEN_W'(order[k] + 2)});
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      e = start_q.pop_front();
      total++;
      if (bus.timer_start !== 1'b1 || bus.grant !== e.grant || bus.timer_length !== e.len) begin
        bad++; $display("FAIL b2b_grant%0d: start=%b grant=%b len=%0d want 1 %b %0d",
                        k, bus.timer_start, bus.grant, bus.timer_length, e.grant, e.len);
      end
      @(negedge clk);
      wait_expiry(seen);
      total++;
      if (!seen) begin bad++; $display("FAIL b2b_expiry_timeout%0d: got none want expiry", k); end
      done_q.push_back(e.grant);
      @(negedge clk);
      ed = done_q.pop_front();
      total++;
      if (bus.done !== ed || bus.grant !== '0) begin
        bad++; $display("FAIL b2b_done%0d: done=%b grant=%b want %b 0000", k, bus.done, bus.grant, ed);
      end
      if (k == 4) bus.req = '0;
    end
    @(negedge clk);
    total++;
    if (bus.timer_start !== 1'b0 || bus.grant !== '0) begin
      bad++; $display("FAIL b2b_quiet: start=%b grant=%b want 0 0000", bus.timer_start, bus.grant);
    end
  endtask

  task automatic test_abort();
    start_t e;
    logic [N_REQ-1:0] ed;
    bit seen;
    do_reset();
    set_len(2, 10'd20);
    set_len(3, 10'd5);
    bus.req = 4'b1100;
    start_q.push_back('{grant: 4'b0100, len: 10'd20});
    start_q.push_back('{grant: 4'b1000, len: 10'd5});
    @(negedge clk);
    e = start_q.pop_front();
    total++;
    if (bus.grant !== e.grant || bus.timer_length !== e.len) begin
      bad++; $display("FAIL abort_first_grant: grant=%b len=%0d want %b %0d", bus.grant, bus.timer_length, e.grant, e.len);
    end
    @(negedge clk);
    bus.req = 4'b1000;
    @(negedge clk);
    total++;
    if (bus.grant !== '0 || bus.done !== '0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL abort_release: grant=%b done=%b busy=%b want 0000 0000 0", bus.grant, bus.done, bus.busy);
    end
    manual_exp = 1'b1;
    @(negedge clk);
    manual_exp = 1'b0;
    e = start_q.pop_front();
    total++;
    if (bus.done !== '0 || bus.timer_start !== 1'b1 || bus.grant !== e.grant || bus.timer_length !== e.len) begin
      bad++; $display("FAIL abort_regrant: done=%b start=%b grant=%b len=%0d want 0000 1 %b %0d",
                      bus.done, bus.timer_start, bus.grant, bus.timer_length, e.grant, e.len);
    end
    @(negedge clk);
    wait_expiry(seen);
    total++;
    if (!seen) begin bad++; $display("FAIL abort_expiry_timeout: got none want expiry"); end
    done_q.push_back(4'b1000);
    @(negedge clk);
    ed = done_q.pop_front();
    total++;
    if (bus.done !== ed) begin bad++; $display("FAIL abort_done3: got %b want %b", bus.done, ed); end
    bus.req = '0;
    @(negedge clk);
  endtask

  task automatic test_len0();
    start_t e;
    logic [N_REQ-1:0] ed;
    int n_done;
    int done_at;
    do_reset();
    set_len(0, 10'd0);
    bus.req = 4'b0001;
    manual_exp = 1'b1;
    start_q.push_back('{grant: 4'b0001, len: 10'd0});
    done_q.push_back(4'b0001);
    @(negedge clk);
    manual_exp = 1'b0;
    e = start_q.pop_front();
    total++;
    if (bus.grant !== e.grant || bus.timer_length !== e.len || bus.timer_start !== 1'b1) begin
      bad++; $display("FAIL len0_grant: grant=%b len=%0d start=%b want %b %0d 1",
                      bus.grant, bus.timer_length, bus.timer_start, e.grant, e.len);
    end
    n_done = 0;
    done_at = -1;
    for (int c = 2; c < 8; c++) begin
      @(negedge clk);
      if (bus.done !== '0) begin
        n_done++;
        if (done_at < 0) begin
          done_at = c;
          ed = done_q.pop_front();
          total++;
          if (bus.done !== ed) begin bad++; $display("FAIL len0_done_value: got %b want %b", bus.done, ed); end
        end
        bus.req = '0;
      end
    end
    total++;
    if (n_done != 1) begin bad++; $display("FAIL len0_done_count: got %0d want 1", n_done); end
    total++;
    if (done_at != 4) begin bad++; $display("FAIL len0_done_cycle: got %0d want 4", done_at); end
  endtask

  task automatic test_async_reset();
    start_t e;
    do_reset();
    set_len(0, 10'd10);
    bus.req = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b1 || bus.grant !== 4'b0001) begin
      bad++; $display("FAIL areset_pre: busy=%b grant=%b want 1 0001", bus.busy, bus.grant);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({bus.grant, bus.done, bus.busy, bus.timer_start, bus.timer_length} !== '0) begin
      bad++; $display("FAIL areset_outputs: grant=%b done=%b busy=%b start=%b len=%0d want all 0",
                      bus.grant, bus.done, bus.busy, bus.timer_start, bus.timer_length);
    end
    bus.req = 4'b1111;
    @(negedge clk);
    reset_n = 1'b1;
    start_q.push_back('{grant: 4'b0001, len: 10'd10});
    @(negedge clk);
    e = start_q.pop_front();
    total++;
    if (bus.timer_start !== 1'b1 || bus.grant !== e.grant || bus.timer_length !== e.len) begin
      bad++; $display("FAIL areset_rr: start=%b grant=%b len=%0d want 1 %b %0d",
                      bus.timer_start, bus.grant, bus.timer_length, e.grant, e.len);
    end
    bus.req = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_expiry_drop();
    start_t e;
    logic [N_REQ-1:0] ed;
    bit seen;
    do_reset();
    set_len(0, 10'd2);
    bus.req = 4'b0001;
    start_q.push_back('{grant: 4'b0001, len: 10'd2});
    @(negedge clk);
    e = start_q.pop_front();
    total++;
    if (bus.grant !== e.grant || bus.timer_length !== e.len) begin
      bad++; $display("FAIL drop_grant: grant=%b len=%0d want %b %0d", bus.grant, bus.timer_length, e.grant, e.len);
    end
    @(negedge clk);
    wait_expiry(seen);
    total++;
    if (!seen) begin bad++; $display("FAIL drop_expiry_timeout: got none want expiry"); end
    bus.req = '0;
    done_q.push_back(4'b0001);
    @(negedge clk);
    ed = done_q.pop_front();
    total++;
    if (bus.done !== ed || bus.grant !== '0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL drop_done: done=%b grant=%b busy=%b want %b 0000 0", bus.done, bus.grant, bus.busy, ed);
    end
    @(negedge clk);
    total++;
    if (bus.done !== '0 || bus.timer_start !== 1'b0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL drop_idle: done=%b start=%b busy=%b want 0000 0 0", bus.done, bus.timer_start, bus.busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req = '0;
    bus.req_length = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_abort();
    test_len0();
    test_async_reset();
    test_expiry_drop();
    total++;
    if (start_q.size() != 0 || done_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_leftover: starts=%0d dones=%0d want 0 0", start_q.size(), done_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
